sevenseg_capture: RTL and testbench
===================================

Name: sevenseg_capture

Overview:
Reader end of the multiplexed active-low seven-segment display interface. Samples the segment bus and digit-enable lines driven by the display scanner. Inverse-decodes each stable segment pattern back to a 4-bit hex nibble and assembles a full NDIGITS-digit value. Sits on the test/debug side of the CPU display path, so the displayed value is readable as a word without a scope.

Parameters:
NDIGITS, 4, number of multiplexed digits (1..8)
STABLE_CYCLES, 8, consecutive identical samples required before a digit is accepted (>=2)

Ports:
clock  input  1  system clock, rising edge
n_reset  input  1  asynchronous active-low reset
seg  input  7  segment bus, active low, bit 0 = segment a … bit 6 = segment g
an  input  NDIGITS  digit enables, active low, bit i = digit i
out_ready  input  1  consumer accepts out_value when out_valid=1
clear_err  input  1  clears the sticky seg_err and overrun flags
out_value  output  4*NDIGITS  assembled value, digit i in bits [4i+3:4i]
out_valid  output  1  out_value holds an unconsumed complete frame
seg_err  output  1  sticky: an unrecognised pattern was held stable
overrun  output  1  sticky: a complete frame was dropped because out_valid was pending

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low on n_reset.
- Reset state:
  - out_value=0, out_valid=0, seg_err=0, overrun=0.
  - Sample registers, stability counter and captured-digit mask all cleared.
- Input stage: seg and an are registered once (s_seg, s_an). All decisions use the registered values.
- Stability counter cnt, width $clog2(STABLE_CYCLES+1):
  - s_an has exactly one zero and (s_seg, s_an) equal the previous sample: cnt increments, saturating at STABLE_CYCLES.
  - s_an has exactly one zero but the sample changed: cnt=1.
  - s_an has zero or more than one low bit: cnt=0.
- Digit accept: occurs on the single cycle cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES, i.e. once per dwell.
  - Pattern recognised: nibble is written to the frame buffer slot of the low anode, and that mask bit is set.
  - Pattern unrecognised (including blank 7'h7F): seg_err is set and the mask is unchanged.
  - A re-accepted digit overwrites its slot.
- Decode table (pattern→nibble, seg[6:0]):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7
  - 00→8, 10→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F
  - All other patterns are errors.
- Frame complete: mask becomes all ones after an accept. On the next edge the mask clears and one of the following applies:
  - out_valid=0, or out_ready=1 in that same cycle: out_value is loaded from the frame buffer and out_valid=1.
  - Otherwise: the frame is dropped, overrun=1, and out_value/out_valid are unchanged.
- Handshake:
  - out_valid falls on the edge where out_valid=1 and out_ready=1, unless a new frame publishes in that same cycle.
  - out_value is stable while out_valid=1.
- clear_err: clears seg_err and overrun on the next edge. If a set event occurs in the same cycle, set wins.
- Latency: the final digit is accepted STABLE_CYCLES+1 edges after its first appearance on the pins. out_valid rises one edge later.
- Reset mid-frame: the partial frame and any pending out_valid are discarded.
- Scan order: any order is allowed; repeats are allowed.

Decomposition:
- Package sevenseg_pkg holds:
  - The seven-segment pattern constants SEG_0..SEG_F and SEG_BLANK.
  - typedef seg_t (logic [6:0]) and nibble_t (logic [3:0]).
  - The constant table used by the encoder side, so both directions share one source.
- Sub-module seg_decode: combinational, seg_t in → nibble_t plus ok flag out. Instantiated once on s_seg.
- Top level contains:
  - The input registers.
  - The stability counter.
  - The anode one-hot check and index encoder.
  - The frame buffer and mask.
  - The output handshake and sticky flags.

Test Plan:
- Frame capture: NDIGITS=4, STABLE_CYCLES=8. Drive each step for 10 cycles: an=4'b1110 seg=7'h79, then an=4'b1101 seg=7'h24, then an=4'b1011 seg=7'h30, then an=4'b0111 seg=7'h19. Expect out_value=16'h4321 and out_valid=1, held until out_ready=1, after which out_valid=0.
- Glitch rejection: dwell digit 0 (seg=7'h40) for only 7 cycles, complete the other three digits with 10-cycle dwells, then re-dwell digit 0 for 10 cycles. Expect no out_valid until the 10-cycle re-dwell; that frame then publishes with nibble 0=0.
- Bad pattern: hold an=4'b1011 seg=7'h7F for 10 cycles. Expect seg_err=1 and digit 2 not captured. Then pulse clear_err and expect seg_err=0.
- Overrun: publish 16'h4321 and keep out_ready=0. Complete a second frame 16'hABCD. Expect overrun=1 and out_value still 16'h4321.
- Invalid anodes: hold an=4'b1100 or 4'b1111 for 20 cycles. Expect cnt=0, no accept, no flags.
- Reset: assert n_reset after 3 of 4 digits are accepted. Expect all outputs 0 immediately. After release, a fresh full scan of 16'h0E08 publishes correctly with no stale nibbles.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions for the display path: active-low patterns
// (bit 0 = segment a ... bit 6 = segment g) and the nibble-to-pattern table.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;

  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_A     = 7'h08;
  localparam seg_t SEG_B     = 7'h03;
  localparam seg_t SEG_C     = 7'h46;
  localparam seg_t SEG_D     = 7'h21;
  localparam seg_t SEG_E     = 7'h06;
  localparam seg_t SEG_F     = 7'h0E;
  localparam seg_t SEG_BLANK = 7'h7F;

  // Indexed by nibble value; the encoder and the reader both use this table.
  localparam seg_t SEG_TABLE [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };

  function automatic seg_t encode_nibble(input nibble_t n);
    return SEG_TABLE[n];
  endfunction

endpackage

// File: rtl/sevenseg_capture_decode.sv
// Combinational inverse of the seven-segment encoder: pattern -> nibble,
// with ok low for any pattern that is not one of the sixteen hex glyphs.
module seg_decode
  import sevenseg_pkg::*;
(
  input  seg_t    seg,
  output nibble_t nib,
  output logic    ok
);

  // Table entries are unique, so at most one index can match.
  always_comb begin
    nib = '0;
    ok  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        nib = nibble_t'(i);
        ok  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Reader side of the multiplexed seven-segment display: waits for each digit
// to dwell stably, decodes it, and publishes a complete multi-digit word.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int NDIGITS       = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                   clock,
  input  logic                   n_reset,
  input  logic [6:0]             seg,
  input  logic [NDIGITS-1:0]     an,
  input  logic                   out_ready,
  input  logic                   clear_err,
  output logic [4*NDIGITS-1:0]   out_value,
  output logic                   out_valid,
  output logic                   seg_err,
  output logic                   overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  seg_t                 s_seg, p_seg;
  logic [NDIGITS-1:0]   s_an, p_an;
  logic [CW-1:0]        cnt;
  logic [NDIGITS-1:0]   mask;
  logic [4*NDIGITS-1:0] frame;
  logic [NDIGITS-1:0]   an_low;
  logic [IW-1:0]        idx;
  logic                 one_hot, same, accept, full, publish, ok;
  nibble_t              nib;

  // p_* holds the previous registered sample so stability is judged on s_*.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      s_seg <= '0;
      s_an  <= '0;
      p_seg <= '0;
      p_an  <= '0;
    end else begin
      s_seg <= seg;
      s_an  <= an;
      p_seg <= s_seg;
      p_an  <= s_an;
    end
  end

  assign an_low  = ~s_an;
  assign one_hot = (an_low != '0) && ((an_low & (an_low - NDIGITS'(1))) == '0);
  assign same    = (s_seg == p_seg) && (s_an == p_an);
  assign accept  = one_hot && same && (cnt == CW'(STABLE_CYCLES - 1));
  assign full    = &mask;
  assign publish = full && (!out_valid || out_ready);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (an_low[i]) idx = IW'(i);
    end
  end

  seg_decode u_decode (
    .seg (s_seg),
    .nib (nib),
    .ok  (ok)
  );

  // Saturation means the 7->8 transition, and so the accept, happens once per dwell.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      cnt <= '0;
    end else if (!one_hot) begin
      cnt <= '0;
    end else if (!same) begin
      cnt <= CW'(1);
    end else if (cnt != CW'(STABLE_CYCLES)) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      mask  <= '0;
      frame <= '0;
    end else if (full) begin
      mask <= '0;
    end else if (accept && ok) begin
      for (int i = 0; i < NDIGITS; i++) begin
        if (idx == IW'(i)) begin
          mask[i]         <= 1'b1;
          frame[4*i +: 4] <= nib;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      out_value <= '0;
      out_valid <= 1'b0;
    end else if (publish) begin
      out_value <= frame;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Set events take priority over clear_err in the same cycle.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      seg_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (accept && !ok)        seg_err <= 1'b1;
      else if (clear_err)       seg_err <= 1'b0;
      if (full && !publish)     overrun <= 1'b1;
      else if (clear_err)       overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture: capture, glitch, bad pattern, overrun,
// invalid anodes and mid-frame reset, with hand-computed expectations.
module tb_sevenseg_capture;

  logic        clock;
  logic        n_reset;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        out_ready;
  logic        clear_err;
  logic [15:0] out_value;
  logic        out_valid;
  logic        seg_err;
  logic        overrun;

  int tests_run = 0;
  int tests_failed = 0;

  sevenseg_capture #(.NDIGITS(4), .STABLE_CYCLES(8)) dut (
    .clock     (clock),
    .n_reset   (n_reset),
    .seg       (seg),
    .an        (an),
    .out_ready (out_ready),
    .clear_err (clear_err),
    .out_value (out_value),
    .out_valid (out_valid),
    .seg_err   (seg_err),
    .overrun   (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Called at a falling edge; holds the pins for the given number of rising edges.
  task automatic apply_stimulus(input logic [3:0] an_v, input logic [6:0] seg_v, input int cycles);
    an  = an_v;
    seg = seg_v;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic pulse_ready();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    n_reset   = 1'b0;
    seg       = 7'h7F;
    an        = 4'b1111;
    out_ready = 1'b0;
    clear_err = 1'b0;
    repeat (3) @(negedge clock);
    check_output("reset_value", 32'(out_value), 32'h0);
    check_output("reset_valid", 32'(out_valid), 32'h0);
    check_output("reset_flags", {30'h0, seg_err, overrun}, 32'h0);
    n_reset = 1'b1;
    @(negedge clock);

    // Frame capture 16'h4321, held until consumed
    apply_stimulus(4'b1110, 7'h79, 10);
    apply_stimulus(4'b1101, 7'h24, 10);
    apply_stimulus(4'b1011, 7'h30, 10);
    check_output("cap_not_yet", 32'(out_valid), 32'h0);
    apply_stimulus(4'b0111, 7'h19, 10);
    check_output("cap_valid", 32'(out_valid), 32'h1);
    check_output("cap_value", 32'(out_value), 32'h4321);
    apply_stimulus(4'b1111, 7'h7F, 5);
    check_output("cap_hold", 32'(out_valid), 32'h1);

    // Overrun: second frame 16'hABCD while 16'h4321 is pending
    apply_stimulus(4'b1110, 7'h21, 10);
    apply_stimulus(4'b1101, 7'h46, 10);
    apply_stimulus(4'b1011, 7'h03, 10);
    apply_stimulus(4'b0111, 7'h08, 10);
    check_output("ovr_flag", 32'(overrun), 32'h1);
    check_output("ovr_value", 32'(out_value), 32'h4321);
    check_output("ovr_valid", 32'(out_valid), 32'h1);
    pulse_ready();
    check_output("ovr_consumed", 32'(out_valid), 32'h0);
    clear_err = 1'b1;
    @(negedge clock);
    clear_err = 1'b0;
    check_output("ovr_cleared", 32'(overrun), 32'h0);

    // Glitch rejection: 7-cycle dwell on digit 0 is ignored
    apply_stimulus(4'b1110, 7'h40, 7);
    apply_stimulus(4'b1101, 7'h24, 10);
    apply_stimulus(4'b1011, 7'h30, 10);
    apply_stimulus(4'b0111, 7'h19, 10);
    check_output("glitch_no_valid", 32'(out_valid), 32'h0);
    apply_stimulus(4'b1110, 7'h40, 10);
    check_output("glitch_valid", 32'(out_valid), 32'h1);
    check_output("glitch_value", 32'(out_value), 32'h4320);
    pulse_ready();
    check_output("glitch_consumed", 32'(out_valid), 32'h0);

    // Invalid anode patterns never count
    apply_stimulus(4'b1100, 7'h40, 20);
    check_output("inv_cnt_two", 32'(dut.cnt), 32'h0);
    apply_stimulus(4'b1111, 7'h40, 20);
    check_output("inv_cnt_none", 32'(dut.cnt), 32'h0);
    check_output("inv_mask", 32'(dut.mask), 32'h0);
    check_output("inv_flags", {29'h0, out_valid, seg_err, overrun}, 32'h0);

    // Bad pattern: blank on digit 2 flags seg_err and leaves it uncaptured
    apply_stimulus(4'b1011, 7'h7F, 10);
    check_output("bad_err", 32'(seg_err), 32'h1);
    apply_stimulus(4'b1110, 7'h40, 10);
    apply_stimulus(4'b1101, 7'h79, 10);
    apply_stimulus(4'b0111, 7'h12, 10);
    check_output("bad_no_valid", 32'(out_valid), 32'h0);
    clear_err = 1'b1;
    @(negedge clock);
    clear_err = 1'b0;
    check_output("bad_cleared", 32'(seg_err), 32'h0);
    apply_stimulus(4'b1011, 7'h02, 10);
    check_output("bad_valid", 32'(out_valid), 32'h1);
    check_output("bad_value", 32'(out_value), 32'h5610);

    // Reset mid-frame with a pending frame and a set error flag
    apply_stimulus(4'b1110, 7'h7F, 10);
    apply_stimulus(4'b1101, 7'h0E, 10);
    apply_stimulus(4'b1011, 7'h0E, 10);
    apply_stimulus(4'b0111, 7'h0E, 10);
    check_output("pre_reset_err", 32'(seg_err), 32'h1);
    n_reset = 1'b0;
    #1;
    check_output("rst_value", 32'(out_value), 32'h0);
    check_output("rst_flags", {29'h0, out_valid, seg_err, overrun}, 32'h0);
    @(negedge clock);
    n_reset = 1'b1;
    @(negedge clock);
    apply_stimulus(4'b1110, 7'h00, 10);
    check_output("rst_no_stale", 32'(out_valid), 32'h0);
    apply_stimulus(4'b1101, 7'h40, 10);
    apply_stimulus(4'b1011, 7'h06, 10);
    apply_stimulus(4'b0111, 7'h40, 10);
    check_output("rst_valid", 32'(out_valid), 32'h1);
    check_output("rst_fresh", 32'(out_value), 32'h0E08);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
